// File: rtl/ysyx_22050243_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the access-size byte mask helper.
package ysyx_22050243_pkg;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_D  = 3'b011;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;
  localparam logic [2:0] FUNCT3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // Right-aligned byte-lane mask for an access size (funct3[1:0]).
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22050243_lsu_align.sv
// Alignment check, byte-lane write mask and lane shift amount for one access.
// Shared by the store and load paths.
module ysyx_22050243_lsu_align
  import ysyx_22050243_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [2:0] addr_lo,
  output logic       misalign,
  output logic [7:0] wmask,
  output logic [5:0] shamt
);

  always_comb begin
    misalign = 1'b0;
    case (funct3[1:0])
      2'b01:   misalign = addr_lo[0];
      2'b10:   misalign = |addr_lo[1:0];
      2'b11:   misalign = |addr_lo;
      default: misalign = 1'b0;
    endcase
    // 111 has no legal meaning; it sizes as D but is always rejected.
    if (funct3 == 3'b111) misalign = 1'b1;
  end

  assign wmask = size_mask(funct3[1:0]) << addr_lo;
  assign shamt = {addr_lo, 3'b000};

endmodule

// File: rtl/ysyx_22050243_lsu.sv
// Load/store unit: one outstanding access, IDLE -> MEM -> RESP, with lane
// shifting/masking for stores and lane extraction plus extension for loads.
module ysyx_22050243_lsu
  import ysyx_22050243_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  data_r_en,
  output logic                  data_w_en,
  output logic [DATA_W/8-1:0]   data_wmask,
  output logic [ADDR_W-1:0]     data_addr,
  output logic [DATA_W-1:0]     data_w,
  input  logic [DATA_W-1:0]     data_r,
  input  logic                  mem_rsp_valid,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_misalign
);

  localparam int LANES = DATA_W / 8;

  lsu_state_e  state_reg;
  logic [2:0]  funct3_reg;
  logic [5:0]  shamt_reg;

  logic        align_misalign;
  logic [7:0]  align_wmask;
  logic [5:0]  align_shamt;
  logic        reject;
  logic [DATA_W-1:0] lane_bits;
  logic [DATA_W-1:0] load_shifted;
  logic [DATA_W-1:0] load_ext;

  ysyx_22050243_lsu_align u_align (
    .funct3   (req_funct3),
    .addr_lo  (req_addr[2:0]),
    .misalign (align_misalign),
    .wmask    (align_wmask),
    .shamt    (align_shamt)
  );

  // Unsigned funct3 encodings have no store meaning and are rejected like 111.
  assign reject = align_misalign | (req_is_store & req_funct3[2]);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_bits[gi*8 +: 8] = {8{align_wmask[gi]}};
    end
  endgenerate

  assign load_shifted = data_r >> shamt_reg;

  always_comb begin
    load_ext = '0;
    case (funct3_reg[1:0])
      2'b00:   load_ext = funct3_reg[2] ? {{(DATA_W-8){1'b0}},  load_shifted[7:0]}
                                        : {{(DATA_W-8){load_shifted[7]}},   load_shifted[7:0]};
      2'b01:   load_ext = funct3_reg[2] ? {{(DATA_W-16){1'b0}}, load_shifted[15:0]}
                                        : {{(DATA_W-16){load_shifted[15]}}, load_shifted[15:0]};
      2'b10:   load_ext = funct3_reg[2] ? {{(DATA_W-32){1'b0}}, load_shifted[31:0]}
                                        : {{(DATA_W-32){load_shifted[31]}}, load_shifted[31:0]};
      default: load_ext = load_shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      funct3_reg   <= 3'b000;
      shamt_reg    <= 6'd0;
      req_ready    <= 1'b0;
      data_r_en    <= 1'b0;
      data_w_en    <= 1'b0;
      data_wmask   <= '0;
      data_addr    <= '0;
      data_w       <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_misalign <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            funct3_reg <= req_funct3;
            shamt_reg  <= align_shamt;
            if (reject) begin
              state_reg    <= RESP;
              rsp_valid    <= 1'b1;
              rsp_misalign <= 1'b1;
              rsp_rdata    <= '0;
            end else begin
              state_reg    <= MEM;
              rsp_misalign <= 1'b0;
              data_addr    <= {req_addr[ADDR_W-1:3], 3'b000};
              if (req_is_store) begin
                data_w_en  <= 1'b1;
                data_wmask <= align_wmask;
                data_w     <= (req_wdata << align_shamt) & lane_bits;
              end else begin
                data_r_en  <= 1'b1;
              end
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        MEM: begin
          if (data_w_en) begin
            data_w_en  <= 1'b0;
            data_wmask <= '0;
            data_w     <= '0;
            rsp_rdata  <= '0;
            rsp_valid  <= 1'b1;
            state_reg  <= RESP;
          end else if (mem_rsp_valid) begin
            data_r_en <= 1'b0;
            rsp_rdata <= load_ext;
            rsp_valid <= 1'b1;
            state_reg <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050243_lsu.sv
// Directed bench for the load/store unit with a small byte-writable memory model.
module tb_ysyx_22050243_lsu;
  import ysyx_22050243_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        data_r_en;
  logic        data_w_en;
  logic [7:0]  data_wmask;
  logic [63:0] data_addr;
  logic [63:0] data_w;
  logic [63:0] data_r;
  logic        mem_rsp_valid = 1'b1;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_misalign;

  logic [63:0] mem [0:15];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ysyx_22050243_lsu #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .data_r_en(data_r_en), .data_w_en(data_w_en), .data_wmask(data_wmask),
    .data_addr(data_addr), .data_w(data_w), .data_r(data_r),
    .mem_rsp_valid(mem_rsp_valid), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_misalign(rsp_misalign)
  );

  assign data_r = mem[data_addr[6:3]];

  always @(posedge clk) begin
    if (data_w_en) begin
      for (int b = 0; b < 8; b++)
        if (data_wmask[b]) mem[data_addr[6:3]][b*8 +: 8] <= data_w[b*8 +: 8];
    end
  end

  // Drives a request for one cycle; returns at the negedge of cycle 1.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic finish_rsp(input string name);
    $display("txn %s: rsp_rdata=%h rsp_misalign=%b", name, rsp_rdata, rsp_misalign);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({data_r_en, data_w_en, rsp_valid, rsp_misalign, req_ready} !== 5'b0 ||
        data_wmask !== 8'h00 || data_addr !== 64'h0 || data_w !== 64'h0 || rsp_rdata !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: r_en=%b w_en=%b rv=%b mis=%b rdy=%b mask=%h addr=%h w=%h rd=%h, all required 0",
               data_r_en, data_w_en, rsp_valid, rsp_misalign, req_ready, data_wmask, data_addr, data_w, rsp_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready: got %b required 1", req_ready);
    end
    $display("txn reset released");
  endtask

  task automatic test_store_d();
    issue(1'b1, FUNCT3_D, 64'h8000_0010, 64'h1122334455667788);
    vectors++;
    if (data_w_en !== 1'b1 || data_r_en !== 1'b0 || data_wmask !== 8'hFF ||
        data_addr !== 64'h8000_0010 || data_w !== 64'h1122334455667788 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL sd_mem: w_en=%b r_en=%b mask=%h addr=%h w=%h rdy=%b required 1 0 ff 80000010 1122334455667788 0",
               data_w_en, data_r_en, data_wmask, data_addr, data_w, req_ready);
    end
    @(negedge clk);
    vectors++;
    if (data_w_en !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 64'h0 || rsp_misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL sd_resp: w_en=%b rv=%b rd=%h mis=%b required 0 1 0 0", data_w_en, rsp_valid, rsp_rdata, rsp_misalign);
    end
    finish_rsp("SD");
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem[2] !== 64'h1122334455667788) begin
      miscompares++;
      $display("FAIL sd_done: rv=%b rdy=%b mem=%h required 0 1 1122334455667788", rsp_valid, req_ready, mem[2]);
    end
  endtask

  task automatic test_store_b();
    issue(1'b1, FUNCT3_B, 64'h8000_0013, 64'h0000_0000_0000_00AB);
    vectors++;
    if (data_w_en !== 1'b1 || data_wmask !== 8'h08 || data_addr !== 64'h8000_0010 || data_w !== 64'h0000_0000_AB00_0000) begin
      miscompares++;
      $display("FAIL sb_mem: w_en=%b mask=%h addr=%h w=%h required 1 08 80000010 00000000ab000000",
               data_w_en, data_wmask, data_addr, data_w);
    end
    @(negedge clk);
    finish_rsp("SB");
    vectors++;
    if (mem[2] !== 64'h11223344AB667788) begin
      miscompares++; $display("FAIL sb_memword: got %h required 11223344ab667788", mem[2]);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3_t  [6] = '{FUNCT3_B, FUNCT3_BU, FUNCT3_H, FUNCT3_WU, FUNCT3_W, FUNCT3_HU};
    logic [63:0] adr_t [6] = '{64'h8000_0008, 64'h8000_0008, 64'h8000_000A, 64'h8000_0008, 64'h8000_0008, 64'h8000_000A};
    logic [63:0] exp_t [6] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h80, 64'hFFFF_FFFF_FFFF_8000,
                              64'h8000_FF80, 64'hFFFF_FFFF_8000_FF80, 64'h8000};
    issue(1'b1, FUNCT3_D, 64'h8000_0008, 64'h0000_0000_8000_FF80);
    @(negedge clk);
    finish_rsp("SD preload");
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, f3_t[i], adr_t[i], 64'h0);
      vectors++;
      if (data_r_en !== 1'b1 || data_w_en !== 1'b0 || data_addr !== 64'h8000_0008) begin
        miscompares++;
        $display("FAIL load%0d_mem: r_en=%b w_en=%b addr=%h required 1 0 80000008", i, data_r_en, data_w_en, data_addr);
      end
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_t[i] || rsp_misalign !== 1'b0 || data_r_en !== 1'b0) begin
        miscompares++;
        $display("FAIL load%0d_resp: rv=%b rd=%h mis=%b r_en=%b required 1 %h 0 0",
                 i, rsp_valid, rsp_rdata, rsp_misalign, data_r_en, exp_t[i]);
      end
      finish_rsp("LOAD");
    end
  endtask

  task automatic test_misalign();
    issue(1'b0, FUNCT3_W, 64'h8000_0006, 64'h0);
    vectors++;
    if (data_r_en !== 1'b0 || rsp_valid !== 1'b1 || rsp_misalign !== 1'b1 || rsp_rdata !== 64'h0) begin
      miscompares++;
      $display("FAIL lw_misalign: r_en=%b rv=%b mis=%b rd=%h required 0 1 1 0", data_r_en, rsp_valid, rsp_misalign, rsp_rdata);
    end
    finish_rsp("LW misaligned");
    issue(1'b1, FUNCT3_BU, 64'h8000_0010, 64'hFF);
    vectors++;
    if (data_w_en !== 1'b0 || rsp_valid !== 1'b1 || rsp_misalign !== 1'b1) begin
      miscompares++;
      $display("FAIL store_bad_funct3: w_en=%b rv=%b mis=%b required 0 1 1", data_w_en, rsp_valid, rsp_misalign);
    end
    finish_rsp("SBU rejected");
    issue(1'b0, FUNCT3_H, 64'h8000_0009, 64'h0);
    vectors++;
    if (data_r_en !== 1'b0 || rsp_misalign !== 1'b1) begin
      miscompares++; $display("FAIL lh_misalign: r_en=%b mis=%b required 0 1", data_r_en, rsp_misalign);
    end
    finish_rsp("LH misaligned");
  endtask

  task automatic test_stall_ld();
    issue(1'b1, FUNCT3_D, 64'h8000_0018, 64'hDEAD_BEEF_CAFE_F00D);
    @(negedge clk);
    finish_rsp("SD preload");
    mem_rsp_valid = 1'b0;
    issue(1'b0, FUNCT3_D, 64'h8000_0018, 64'h0);
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) mem_rsp_valid = 1'b1;
      vectors++;
      if (data_r_en !== 1'b1 || data_addr !== 64'h8000_0018 || rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL ld_stall_c%0d: r_en=%b addr=%h rv=%b required 1 80000018 0", c, data_r_en, data_addr, rsp_valid);
      end
      @(negedge clk);
    end
    for (int c = 0; c < 2; c++) begin
      vectors++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 64'hDEAD_BEEF_CAFE_F00D || data_r_en !== 1'b0) begin
        miscompares++;
        $display("FAIL ld_hold%0d: rv=%b rdy=%b rd=%h r_en=%b required 1 0 deadbeefcafef00d 0",
                 c, rsp_valid, req_ready, rsp_rdata, data_r_en);
      end
      @(negedge clk);
    end
    finish_rsp("LD stalled");
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++; $display("FAIL ld_done: rv=%b rdy=%b required 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_async_reset();
    mem_rsp_valid = 1'b0;
    issue(1'b0, FUNCT3_D, 64'h8000_0010, 64'h0);
    vectors++;
    if (data_r_en !== 1'b1) begin
      miscompares++; $display("FAIL rst_pre: r_en=%b required 1", data_r_en);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (data_r_en !== 1'b0 || data_w_en !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async: r_en=%b w_en=%b rv=%b required 0 0 0", data_r_en, data_w_en, rsp_valid);
    end
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || data_r_en !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_after%0d: rdy=%b rv=%b r_en=%b required 1 0 0", c, req_ready, rsp_valid, data_r_en);
      end
      @(negedge clk);
    end
    $display("txn async reset during load");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_store_d();
    test_store_b();
    test_loads();
    test_misalign();
    test_stall_ld();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
